mem_req_arbiter: RTL and testbench

//  Shares one memory_system/DCache request port between two requesters (R0 = load/store queue,
//  R1 = secondary client, e.g. I-side refill/DMA). Round-robin arbitration, remaps requester IDs

---
 rtl/mem_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin front end for a single memory request port.
// Remaps requester IDs onto 16 memory tags and routes responses back to their owners.
module mem_req_arbiter #(
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_data,
  input  logic        r0_rw,
  input  logic [3:0]  r0_id,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_data,
  input  logic        r1_rw,
  input  logic [3:0]  r1_id,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_rw,
  output logic [3:0]  mem_id,
  input  logic        mem_stall,
  input  logic        mem_ready,
  input  logic [3:0]  mem_rid,
  input  logic [31:0] mem_rdata,
  output logic        rsp0_valid,
  output logic [3:0]  rsp0_id,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  output logic [3:0]  rsp1_id,
  output logic [31:0] rsp1_data,
  output logic        busy,
  output logic        err_unexp
);

  localparam logic [4:0] MaxCnt = 5'(MAX_OUTST);

  logic [15:0] tag_busy_q, tag_busy_d;
  logic [15:0] tag_owner_q, tag_owner_d;
  logic [3:0]  tag_rid_q [16];
  logic [3:0]  tag_rid_d [16];
  logic [4:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        pref_q, pref_d;  // 1: R1 preferred on a tie
  logic        err_q, err_d;

  logic        mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
  logic [3:0]  mem_id_q, mem_id_d;
  logic        rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [3:0]  rsp0_id_q, rsp0_id_d, rsp1_id_q, rsp1_id_d;
  logic [31:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

  logic       elig0, elig1, can_grant, gnt0, gnt1, hit, hit_owner;
  logic [3:0] free_tag;

  always_comb begin
    elig0     = r0_valid && (cnt0_q < MaxCnt);
    elig1     = r1_valid && (cnt1_q < MaxCnt);
    can_grant = !mem_stall && !(&tag_busy_q);
    gnt0      = can_grant && elig0 && (!elig1 || !pref_q);
    gnt1      = can_grant && elig1 && (!elig0 || pref_q);

    // Descending scan leaves the lowest-index free tag selected.
    free_tag = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!tag_busy_q[i]) free_tag = 4'(i);
    end

    hit       = mem_ready && tag_busy_q[mem_rid];
    hit_owner = tag_owner_q[mem_rid];

    tag_busy_d  = tag_busy_q;
    tag_owner_d = tag_owner_q;
    tag_rid_d   = tag_rid_q;
    pref_d      = pref_q;
    err_d       = err_q || (mem_ready && !tag_busy_q[mem_rid]);

    mem_valid_d = gnt0 || gnt1;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_rw_d    = mem_rw_q;
    mem_id_d    = mem_id_q;

    // A tag freed here is never the one granted: grants pick from the start-of-cycle free set.
    if (hit) tag_busy_d[mem_rid] = 1'b0;

    if (gnt0 || gnt1) begin
      tag_busy_d[free_tag]  = 1'b1;
      tag_owner_d[free_tag] = gnt1;
      tag_rid_d[free_tag]   = gnt1 ? r1_id : r0_id;
      pref_d                = gnt0;
      mem_addr_d            = gnt1 ? r1_addr : r0_addr;
      mem_data_d            = gnt1 ? r1_data : r0_data;
      mem_rw_d              = gnt1 ? r1_rw : r0_rw;
      mem_id_d              = free_tag;
    end

    cnt0_d = cnt0_q + 5'(gnt0) - 5'(hit && !hit_owner);
    cnt1_d = cnt1_q + 5'(gnt1) - 5'(hit && hit_owner);

    rsp0_valid_d = hit && !hit_owner;
    rsp1_valid_d = hit && hit_owner;
    rsp0_id_d    = rsp0_valid_d ? tag_rid_q[mem_rid] : rsp0_id_q;
    rsp0_data_d  = rsp0_valid_d ? mem_rdata : rsp0_data_q;
    rsp1_id_d    = rsp1_valid_d ? tag_rid_q[mem_rid] : rsp1_id_q;
    rsp1_data_d  = rsp1_valid_d ? mem_rdata : rsp1_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_busy_q   <= '0;
      tag_owner_q  <= '0;
      for (int i = 0; i < 16; i++) tag_rid_q[i] <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      pref_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_rw_q     <= 1'b0;
      mem_id_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_id_q    <= '0;
      rsp0_data_q  <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_id_q    <= '0;
      rsp1_data_q  <= '0;
    end else begin
      tag_busy_q   <= tag_busy_d;
      tag_owner_q  <= tag_owner_d;
      tag_rid_q    <= tag_rid_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      pref_q       <= pref_d;
      err_q        <= err_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_rw_q     <= mem_rw_d;
      mem_id_q     <= mem_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_id_q    <= rsp0_id_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_id_q    <= rsp1_id_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign r0_ready   = gnt0;
  assign r1_ready   = gnt1;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_rw     = mem_rw_q;
  assign mem_id     = mem_id_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_id    = rsp0_id_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_id    = rsp1_id_q;
  assign rsp1_data  = rsp1_data_q;
  assign busy       = |tag_busy_q;
  assign err_unexp  = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: per-cycle vector table plus hand-written
// sequences for tag exhaustion, stall and mid-traffic reset.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r0_rw, r1_valid, r1_ready, r1_rw;
  logic [31:0] r0_addr, r0_data, r1_addr, r1_data;
  logic [3:0]  r0_id, r1_id;
  logic        mem_valid, mem_rw, mem_stall, mem_ready;
  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic [3:0]  mem_id, mem_rid;
  logic        rsp0_valid, rsp1_valid, busy, err_unexp;
  logic [3:0]  rsp0_id, rsp1_id;
  logic [31:0] rsp0_data, rsp1_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.MAX_OUTST(8)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_data(r0_data),
    .r0_rw(r0_rw), .r0_id(r0_id),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_data(r1_data),
    .r1_rw(r1_rw), .r1_id(r1_id),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_rw(mem_rw),
    .mem_id(mem_id), .mem_stall(mem_stall), .mem_ready(mem_ready), .mem_rid(mem_rid),
    .mem_rdata(mem_rdata),
    .rsp0_valid(rsp0_valid), .rsp0_id(rsp0_id), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_id(rsp1_id), .rsp1_data(rsp1_data),
    .busy(busy), .err_unexp(err_unexp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic v0, v1; logic [3:0] id0, id1; logic stall, mrdy; logic [3:0] rid; logic [31:0] rdata;
    logic rdy0, rdy1, mv; logic [3:0] mid; logic s0v; logic [3:0] s0id;
    logic s1v; logic [3:0] s1id; logic bsy, err;
  } vec_t;

  vec_t tbl [17];

  always_comb begin
    r0_addr = 32'h1000_0000 | {28'd0, r0_id};
    r1_addr = 32'h2000_0000 | {28'd0, r1_id};
  end

  task automatic idle();
    r0_valid = 0; r1_valid = 0; mem_stall = 0; mem_ready = 0; mem_rid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int g0, g1;

  initial begin
    r0_id = 0; r1_id = 0; r0_data = 32'h0000_AAAA; r1_data = 32'h0000_BBBB;
    r0_rw = 1'b0; r1_rw = 1'b1;
    rst = 1'b1;
    idle();
    #1;
    chk("reset mem_valid", mem_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err_unexp, 0);
    chk("reset rsp0_valid", rsp0_valid, 0);
    chk("reset rsp1_valid", rsp1_valid, 0);
    chk("reset mem_id", mem_id, 0);
    do_reset();

    // v0 v1 id0 id1 stall mrdy rid rdata | rdy0 rdy1 mv mid s0v s0id s1v s1id bsy err
    tbl[0]  = '{1,0,5,0,0,0,0,0,            1,0,1,0, 0,0,0,0, 1,0};
    tbl[1]  = '{0,0,0,0,0,0,0,0,            0,0,0,0, 0,0,0,0, 1,0};
    tbl[2]  = '{0,0,0,0,0,1,0,32'hDEADBEEF, 0,0,0,0, 1,5,0,0, 0,0};
    tbl[3]  = '{0,0,0,0,0,0,0,0,            0,0,0,0, 0,0,0,0, 0,0};
    tbl[4]  = '{1,1,1,2,0,0,0,0,            0,1,1,0, 0,0,0,0, 1,0};
    tbl[5]  = '{1,1,7,6,0,0,0,0,            1,0,1,1, 0,0,0,0, 1,0};
    tbl[6]  = '{1,1,8,4'hC,0,0,0,0,         0,1,1,2, 0,0,0,0, 1,0};
    tbl[7]  = '{1,1,3,4'hD,0,0,0,0,         1,0,1,3, 0,0,0,0, 1,0};
    tbl[8]  = '{0,0,0,0,0,1,3,32'h33,       0,0,0,0, 1,3,0,0, 1,0};
    tbl[9]  = '{0,0,0,0,0,1,1,32'h11,       0,0,0,0, 1,7,0,0, 1,0};
    tbl[10] = '{0,0,0,0,0,1,2,32'h22,       0,0,0,0, 0,0,1,4'hC, 1,0};
    tbl[11] = '{1,0,9,0,0,1,0,32'h44,       1,0,1,1, 0,0,1,2, 1,0};
    tbl[12] = '{0,0,0,0,0,1,1,32'h55,       0,0,0,0, 1,9,0,0, 0,0};
    tbl[13] = '{0,0,0,0,0,1,9,32'h66,       0,0,0,0, 0,0,0,0, 0,1};
    tbl[14] = '{0,0,0,0,0,0,0,0,            0,0,0,0, 0,0,0,0, 0,1};
    tbl[15] = '{1,1,4,5,1,0,0,0,            0,0,0,0, 0,0,0,0, 0,1};
    tbl[16] = '{1,1,4,5,0,0,0,0,            0,1,1,0, 0,0,0,0, 1,1};

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      r0_valid = tbl[i].v0; r1_valid = tbl[i].v1; r0_id = tbl[i].id0; r1_id = tbl[i].id1;
      mem_stall = tbl[i].stall; mem_ready = tbl[i].mrdy; mem_rid = tbl[i].rid;
      mem_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d r0_ready", i), r0_ready, tbl[i].rdy0);
      chk($sformatf("v%0d r1_ready", i), r1_ready, tbl[i].rdy1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mem_valid", i), mem_valid, tbl[i].mv);
      if (tbl[i].mv) begin
        chk($sformatf("v%0d mem_id", i), mem_id, tbl[i].mid);
        chk($sformatf("v%0d mem_addr", i), mem_addr,
            tbl[i].rdy1 ? (32'h2000_0000 | tbl[i].id1) : (32'h1000_0000 | tbl[i].id0));
        chk($sformatf("v%0d mem_rw", i), mem_rw, tbl[i].rdy1);
      end
      chk($sformatf("v%0d rsp0_valid", i), rsp0_valid, tbl[i].s0v);
      chk($sformatf("v%0d rsp1_valid", i), rsp1_valid, tbl[i].s1v);
      if (tbl[i].s0v) begin
        chk($sformatf("v%0d rsp0_id", i), rsp0_id, tbl[i].s0id);
        chk($sformatf("v%0d rsp0_data", i), rsp0_data, tbl[i].rdata);
      end
      if (tbl[i].s1v) begin
        chk($sformatf("v%0d rsp1_id", i), rsp1_id, tbl[i].s1id);
        chk($sformatf("v%0d rsp1_data", i), rsp1_data, tbl[i].rdata);
      end
      chk($sformatf("v%0d busy", i), busy, tbl[i].bsy);
      chk($sformatf("v%0d err_unexp", i), err_unexp, tbl[i].err);
    end

    // Per-requester limit and full tag pool: R0 takes tags 0..7, R1 tags 8..15.
    do_reset();
    g0 = 0; g1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      r0_valid = 1; r0_id = 4'hA;
      #1;
      if (r0_ready) g0++;
    end
    chk("r0 grants at limit", g0, 8);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      r1_valid = 1; r1_id = 4'(g1);
      #1;
      if (r1_ready) g1++;
      if (r0_ready) g0++;
    end
    chk("r0 grants total", g0, 8);
    chk("r1 grants at limit", g1, 8);
    @(negedge clk);
    mem_ready = 1; mem_rid = 4'd5; mem_rdata = 32'h5555;
    #1;
    chk("full r0_ready", r0_ready, 0);
    chk("full r1_ready", r1_ready, 0);
    @(posedge clk);
    #1;
    chk("full rsp0_valid", rsp0_valid, 1);
    chk("full rsp0_id", rsp0_id, 4'hA);
    @(negedge clk);
    mem_ready = 0;
    #1;
    chk("refill r0_ready", r0_ready, 1);
    chk("refill r1_ready", r1_ready, 0);
    @(posedge clk);
    #1;
    chk("refill mem_valid", mem_valid, 1);
    chk("refill mem_id", mem_id, 5);

    // Stall three cycles with both valid; a response still routes during the stall.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_stall = 1; mem_ready = (i == 0); mem_rid = 4'd12; mem_rdata = 32'hC0C0;
      #1;
      chk($sformatf("stall%0d r0_ready", i), r0_ready, 0);
      chk($sformatf("stall%0d r1_ready", i), r1_ready, 0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d mem_valid", i), mem_valid, 0);
      chk($sformatf("stall%0d rsp1_valid", i), rsp1_valid, (i == 0));
      if (i == 0) chk("stall rsp1_id", rsp1_id, 4);
    end
    @(negedge clk);
    mem_stall = 0; mem_ready = 0;
    #1;
    chk("unstall r1_ready", r1_ready, 1);
    @(posedge clk);
    #1;
    chk("unstall mem_id", mem_id, 12);

    // Duplicate response to tag 0 is unexpected; then reset mid-traffic.
    @(negedge clk);
    idle(); mem_ready = 1; mem_rid = 4'd0;
    @(negedge clk);
    #1;
    chk("dup rsp0_valid first", rsp0_valid, 1);
    @(posedge clk);
    #1;
    chk("dup rsp0_valid second", rsp0_valid, 0);
    chk("dup err_unexp", err_unexp, 1);
    @(negedge clk);
    mem_ready = 0;
    rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst err_unexp", err_unexp, 0);
    chk("midrst mem_valid", mem_valid, 0);
    chk("midrst mem_id", mem_id, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1; mem_rid = 4'd3;
    @(posedge clk);
    #1;
    chk("late rsp0_valid", rsp0_valid, 0);
    chk("late err_unexp", err_unexp, 1);
    chk("late busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
